sik_dmem_responder: RTL and testbench

- Data-memory responder for the dual-thread SIK pipeline. Serves load/store requests from thread 0 and thread 1 over valid/ready channels.
- Arbitrates round-robin between the two threads, performs one access per cycle against an internal word-addressed array, and returns load data in order through a response FIFO with a thread tag.
- Sits between the pipeline's load/store stage (the initiator) and data memory.

---
 rtl/sik_dmem_responder.sv | 131 +++++++++++++
 tb/tb_sik_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sik_dmem_responder.sv
// sik_dmem_responder: data-memory responder for the dual-thread SIK pipeline.
// Round-robin arbitration between two request channels, one access per cycle
// against a word-addressed array, in-order load responses through a small
// tagged FIFO.
// Optional feature macro: SIK_DMEM_STORE_ACK_EN (stores also enqueue a response).
module sik_dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [15:0] req0_addr,
    input  logic [15:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [15:0] req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_tid,
    output logic [15:0] rsp_rdata
);

`ifdef SIK_DMEM_STORE_ACK_EN
    localparam logic STORE_ACK = 1'b1;
`else
    localparam logic STORE_ACK = 1'b0;
`endif

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]           mem [0:(1 << DEPTH_LOG2) - 1];
    logic [15:0]           fifo_data [0:FIFO_DEPTH - 1];
    logic                  fifo_tid  [0:FIFO_DEPTH - 1];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic                  s1_valid;
    logic                  s1_tid;
    logic [15:0]           s1_data;
    logic                  last_grant;

    logic                  grant0;
    logic                  grant1;
    logic                  credit_ok;
    logic                  accept;
    logic                  acc_tid;
    logic                  acc_we;
    logic                  acc_rsp;
    logic [DEPTH_LOG2-1:0] acc_addr;
    logic [15:0]           acc_wdata;
    logic                  push;
    logic                  pop;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{req0_addr[15:DEPTH_LOG2], req1_addr[15:DEPTH_LOG2]};

    // Arbitration, credit check, accepted-request mux and FIFO head view.
    always_comb begin
        credit_ok  = (count + CW'(s1_valid)) < CW'(FIFO_DEPTH);
        // Tie goes to the thread that did not win the last transfer.
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        grant0     = req0_valid & ~grant1;
        req0_ready = reset & grant0 & (credit_ok | (req0_we & ~STORE_ACK));
        req1_ready = reset & grant1 & (credit_ok | (req1_we & ~STORE_ACK));
        accept     = req0_ready | req1_ready;
        acc_tid    = req1_ready;
        acc_we     = acc_tid ? req1_we : req0_we;
        acc_addr   = acc_tid ? req1_addr[DEPTH_LOG2-1:0] : req0_addr[DEPTH_LOG2-1:0];
        acc_wdata  = acc_tid ? req1_wdata : req0_wdata;
        acc_rsp    = accept & (~acc_we | STORE_ACK);
        rsp_valid  = (count != '0);
        rsp_tid    = rsp_valid ? fifo_tid[rd_ptr] : 1'b0;
        rsp_rdata  = rsp_valid ? fifo_data[rd_ptr] : '0;
        pop        = rsp_valid & rsp_ready;
        push       = s1_valid;
    end

    // Array write and stage-1 capture; the read sees stores from earlier edges only.
    always_ff @(posedge clk) begin
        if (accept & acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
        if (acc_rsp) begin
            s1_tid  <= acc_tid;
            s1_data <= acc_we ? acc_wdata : mem[acc_addr];
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= s1_data;
            fifo_tid[wr_ptr]  <= s1_tid;
        end
    end

    // Control state: stage-1 valid, round-robin pointer, FIFO pointers and count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            last_grant <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            s1_valid <= acc_rsp;
            if (accept) begin
                last_grant <= acc_tid;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push & ~pop) begin
                count <= count + CW'(1);
            end else if (pop & ~push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sik_dmem_responder.sv
// Self-checking bench for sik_dmem_responder: directed scenarios plus a
// randomized run, all checked against a transaction-level reference model.
module tb_sik_dmem_responder;

    localparam int FD = 4;
`ifdef SIK_DMEM_STORE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_we;
    logic [15:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [15:0] req1_addr, req1_wdata;
    logic        rsp_valid, rsp_ready, rsp_tid;
    logic [15:0] rsp_rdata;

    sik_dmem_responder #(.DEPTH_LOG2(10), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_tid(rsp_tid), .rsp_rdata(rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory contents, accepted-but-unconsumed responses
    // (each visible from a given cycle on), and the thread that won last.
    typedef struct {
        bit          tid;
        logic [15:0] data;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    logic [15:0] mmem [int];
    bit          last_winner;
    int          cyc;
    int          acc;
    int          tests;
    int          fails;

    // One clock cycle: drive, compare outputs with the model, advance the model.
    task automatic step(input bit v0, input bit we0, input logic [15:0] a0, input logic [15:0] d0,
                        input bit v1, input bit we1, input logic [15:0] a1, input logic [15:0] d1,
                        input bit rr);
        bit          ev, g0, g1, e0, e1, credit, t, we;
        logic [15:0] a, d, rd;
        int          idx;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        rsp_ready  = rr;
        #1;
        ev = (q.size() > 0) && (q[0].due <= cyc);
        tests++;
        if (rsp_valid !== ev) begin
            fails++;
            $display("FAIL rsp_valid cyc=%0d got %b exp %b", cyc, rsp_valid, ev);
        end
        if (ev) begin
            tests++;
            if (rsp_tid !== q[0].tid || rsp_rdata !== q[0].data) begin
                fails++;
                $display("FAIL rsp_payload cyc=%0d got tid=%b data=%h exp tid=%b data=%h",
                         cyc, rsp_tid, rsp_rdata, q[0].tid, q[0].data);
            end
        end
        credit = q.size() < FD;
        g0 = v0 && (!v1 || last_winner);
        g1 = v1 && !g0;
        e0 = g0 && (credit || (we0 && !ACK));
        e1 = g1 && (credit || (we1 && !ACK));
        tests++;
        if (req0_ready !== e0 || req1_ready !== e1) begin
            fails++;
            $display("FAIL ready cyc=%0d got %b%b exp %b%b", cyc, req0_ready, req1_ready, e0, e1);
        end
        acc = e0 ? 0 : (e1 ? 1 : -1);
        if (ev && rr) void'(q.pop_front());
        if (acc >= 0) begin
            t  = (acc == 1);
            we = t ? we1 : we0;
            a  = t ? a1 : a0;
            d  = t ? d1 : d0;
            idx = int'(a[9:0]);
            if (we) mmem[idx] = d;
            rd = mmem.exists(idx) ? mmem[idx] : 16'hxxxx;
            if (!we || ACK) q.push_back('{tid: t, data: (we ? d : rd), due: cyc + 2});
            last_winner = t;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rr);
    endtask

    // Asserts reset with both channels requesting; outputs must drop at once.
    task automatic apply_reset();
        req0_valid = 1; req0_we = 0; req1_valid = 1; req1_we = 0;
        reset = 0;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            rsp_tid !== 1'b0 || rsp_rdata !== 16'h0000) begin
            fails++;
            $display("FAIL reset_outputs got v=%b r0=%b r1=%b tid=%b data=%h exp all zero",
                     rsp_valid, req0_ready, req1_ready, rsp_tid, rsp_rdata);
        end
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        reset = 1;
        q.delete();
        last_winner = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        idle(3, 1);
    endtask

    task automatic test_store_load();
        step(1, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0, 1);
        step(1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 1);
        idle(5, 1);
    endtask

    task automatic test_round_robin();
        int exp_t;
        apply_reset();
        step(0, 0, 0, 0, 1, 1, 16'h0001, 16'h1111, 1);
        step(0, 0, 0, 0, 1, 1, 16'h0002, 16'h2222, 1);
        idle(2, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0, 1);
            exp_t = i % 2;
            tests++;
            if (acc != exp_t) begin
                fails++;
                $display("FAIL rr_grant i=%0d got %0d exp %0d", i, acc, exp_t);
            end
        end
        idle(6, 1);
    endtask

    task automatic test_backpressure();
        int n;
        logic [15:0] a;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            a = 16'(n % 2 + 1);
            step(0, 0, 0, 0, 1, 0, a, 0, 0);
            if (acc == 1) n++;
        end
        tests++;
        if (n != FD) begin
            fails++;
            $display("FAIL credit_accepts got %0d exp %0d", n, FD);
        end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            a = 16'(n % 2 + 1);
            step(0, 0, 0, 0, 1, 0, a, 0, 1);
            if (acc == 1) n++;
        end
        tests++;
        if (n == 0) begin
            fails++;
            $display("FAIL credit_resume got %0d accepts exp >0", n);
        end
        idle(8, 1);
    endtask

    task automatic test_wrap();
        step(1, 1, 16'h0400, 16'h1234, 0, 0, 0, 0, 1);
        step(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1);
        idle(4, 1);
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 4; i++) step(1, 0, 16'(i % 2 + 1), 0, 0, 0, 0, 0, 0);
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_valid got %b exp 1", rsp_valid);
        end
        apply_reset();
        idle(5, 1);
        step(1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0, 1);
        tests++;
        if (acc != 0) begin
            fails++;
            $display("FAIL post_reset_tie got %0d exp 0", acc);
        end
        idle(5, 1);
    endtask

`ifdef SIK_DMEM_STORE_ACK_EN
    task automatic test_store_ack();
        step(0, 0, 0, 0, 1, 1, 16'h0005, 16'h00AA, 1);
        idle(1, 1);
        tests++;
        #1;
        if (rsp_valid !== 1'b1 || rsp_tid !== 1'b1 || rsp_rdata !== 16'h00AA) begin
            fails++;
            $display("FAIL store_ack got v=%b tid=%b data=%h exp v=1 tid=1 data=00aa",
                     rsp_valid, rsp_tid, rsp_rdata);
        end
        @(negedge clk);
        idle(4, 1);
    endtask
`endif

    task automatic test_random();
        bit          p0v, p0we, p1v, p1we;
        logic [15:0] p0a, p0d, p1a, p1d;
        for (int i = 0; i < 16; i++) step(1, 1, 16'(i), 16'($urandom), 0, 0, 0, 0, 1);
        p0v = 0; p1v = 0;
        p0we = 0; p1we = 0; p0a = 0; p1a = 0; p0d = 0; p1d = 0;
        for (int i = 0; i < 400; i++) begin
            if (!p0v && $urandom_range(0, 3) != 0) begin
                p0v = 1; p0we = ($urandom_range(0, 2) == 0);
                p0a = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 63)) << 10);
                p0d = 16'($urandom);
            end
            if (!p1v && $urandom_range(0, 3) != 0) begin
                p1v = 1; p1we = ($urandom_range(0, 2) == 0);
                p1a = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 63)) << 10);
                p1d = 16'($urandom);
            end
            step(p0v, p0we, p0a, p0d, p1v, p1we, p1a, p1d, ($urandom_range(0, 2) != 0));
            if (acc == 0) p0v = 0;
            if (acc == 1) p1v = 0;
        end
        idle(12, 1);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; acc = -1; last_winner = 1'b1;
        reset = 0; rsp_ready = 0;
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_midflight();
`ifdef SIK_DMEM_STORE_ACK_EN
        test_store_ack();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
